// File: rtl/regs_pkg.sv
// Shared parameters, debug FSM state encoding and debug request payload for regs_file.
package regs_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned NREG         = 32;
  localparam int unsigned REG_AW       = 5;
  localparam int unsigned DBG_MAX_WAIT = 15;

  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dbg_state_t;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   wdata;
  } dbg_req_t;

endpackage

// File: rtl/regs_file_if.sv
// Register file bus: id read ports, ex write port and debug handshake.
interface regs_file_if;
  import regs_pkg::*;

  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              reg_wen;
  logic [REG_AW-1:0] reg_waddr;
  logic [XLEN-1:0]   reg_wdata;
  logic              dbg_req;
  logic              dbg_we;
  logic [REG_AW-1:0] dbg_addr;
  logic [XLEN-1:0]   dbg_wdata;
  logic              dbg_ack;
  logic [XLEN-1:0]   dbg_rdata;
  logic              dbg_busy;

  modport master (
    output rs1_addr, rs2_addr, reg_wen, reg_waddr, reg_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  rs1_data, rs2_data, dbg_ack, dbg_rdata, dbg_busy
  );

  modport slave (
    input  rs1_addr, rs2_addr, reg_wen, reg_waddr, reg_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output rs1_data, rs2_data, dbg_ack, dbg_rdata, dbg_busy
  );

endinterface

// File: rtl/regs_dbg_ctrl.sv
// Debug access FSM: latches a request, defers writes behind core writes up to a limit, acks once.
module regs_dbg_ctrl
  import regs_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DBG_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [REG_AW-1:0] dbg_addr_i,
  input  logic [XLEN-1:0]   dbg_wdata_i,
  input  logic              reg_wen_i,
  output logic              dbg_wr_en_c_o,
  output logic              dbg_rd_c_o,
  output logic [REG_AW-1:0] dbg_wr_addr_o,
  output logic [XLEN-1:0]   dbg_wr_data_o,
  output logic              dbg_ack_o,
  output logic              dbg_busy_o
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  dbg_state_t        state_q, state_d;
  dbg_req_t          req_q, req_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    cnt_d         = cnt_q;
    dbg_wr_en_c_o = 1'b0;
    dbg_rd_c_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dbg_req_i) begin
          req_d   = '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i};
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!req_q.we) begin
          dbg_rd_c_o = 1'b1;
          state_d    = RESP;
        end else if (!reg_wen_i || cnt_q == WAIT_W'(MAX_WAIT)) begin
          dbg_wr_en_c_o = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Ack and busy are registered copies of what the next state will be.
    ack_d  = (state_d == RESP);
    busy_d = (state_d != IDLE);
  end

  assign dbg_wr_addr_o = req_q.addr;
  assign dbg_wr_data_o = req_q.wdata;
  assign dbg_ack_o     = ack_q;
  assign dbg_busy_o    = busy_q;

endmodule

// File: rtl/regs_file.sv
// 32x32 integer register file with two read ports, a core write port and a debug port.
// Define REGS_BYPASS_EN to forward same-cycle core writes onto the read ports.
module regs_file
  import regs_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  regs_file_if.slave rf_if
);

  logic [XLEN-1:0]   regs_q [NREG];
  logic              dbg_wr_en_c;
  logic              dbg_rd_c;
  logic [REG_AW-1:0] dbg_addr;
  logic [XLEN-1:0]   dbg_wdata;
  logic [XLEN-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic              dbg_ack;
  logic              dbg_busy;

  regs_dbg_ctrl #(.MAX_WAIT(DBG_MAX_WAIT)) u_dbg_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .dbg_req_i     (rf_if.dbg_req),
    .dbg_we_i      (rf_if.dbg_we),
    .dbg_addr_i    (rf_if.dbg_addr),
    .dbg_wdata_i   (rf_if.dbg_wdata),
    .reg_wen_i     (rf_if.reg_wen),
    .dbg_wr_en_c_o (dbg_wr_en_c),
    .dbg_rd_c_o    (dbg_rd_c),
    .dbg_wr_addr_o (dbg_addr),
    .dbg_wr_data_o (dbg_wdata),
    .dbg_ack_o     (dbg_ack),
    .dbg_busy_o    (dbg_busy)
  );

  // Debug write is issued after the core write so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      if (rf_if.reg_wen && rf_if.reg_waddr != ZERO_REG) regs_q[rf_if.reg_waddr] <= rf_if.reg_wdata;
      if (dbg_wr_en_c && dbg_addr != ZERO_REG) regs_q[dbg_addr] <= dbg_wdata;
    end
  end

  always_comb begin
    dbg_rdata_d = dbg_rdata_q;
    if (dbg_rd_c) dbg_rdata_d = (dbg_addr == ZERO_REG) ? '0 : regs_q[dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dbg_rdata_q <= '0;
    else        dbg_rdata_q <= dbg_rdata_d;
  end

  always_comb begin
    rf_if.rs1_data = '0;
    rf_if.rs2_data = '0;
    if (rst_n) begin
      if (rf_if.rs1_addr != ZERO_REG) rf_if.rs1_data = regs_q[rf_if.rs1_addr];
      if (rf_if.rs2_addr != ZERO_REG) rf_if.rs2_data = regs_q[rf_if.rs2_addr];
`ifdef REGS_BYPASS_EN
      if (rf_if.reg_wen && rf_if.reg_waddr != ZERO_REG) begin
        if (rf_if.reg_waddr == rf_if.rs1_addr) rf_if.rs1_data = rf_if.reg_wdata;
        if (rf_if.reg_waddr == rf_if.rs2_addr) rf_if.rs2_data = rf_if.reg_wdata;
      end
`endif
    end
  end

  assign rf_if.dbg_ack   = dbg_ack;
  assign rf_if.dbg_rdata = dbg_rdata_q;
  assign rf_if.dbg_busy  = dbg_busy;

endmodule

// File: tb/tb_regs_file.sv
// Self-checking bench for regs_file: vector table, directed debug sequences, random traffic vs array model.
module tb_regs_file;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regs_file_if bus ();
  regs_file dut (.clk(clk), .rst_n(rst_n), .rf_if(bus.slave));

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mem_m [32];

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int max, output int n);
    n = 0;
    while (bus.dbg_ack !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a, input logic wen,
                                           input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'h0 : mem_m[a];
`ifdef REGS_BYPASS_EN
    if (wen && wa != 5'd0 && wa == a) v = wd;
`endif
    return v;
  endfunction

  task automatic core_wr(input logic [4:0] a, input logic [31:0] d);
    bus.reg_wen = 1'b1; bus.reg_waddr = a; bus.reg_wdata = d;
    tick();
    bus.reg_wen = 1'b0;
    if (a != 5'd0) mem_m[a] = d;
  endtask

  task automatic dbg_txn(input logic we, input logic [4:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rdata);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    tick();
    bus.dbg_req = 1'b0;
    wait_ack(20, lat);
    lat++;
    rdata = bus.dbg_rdata;
    tick();
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic wen;
    logic [4:0] wa, a1, a2;
    logic [31:0] wd;

    rst_n = 1'b0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.reg_wen = 1'b0; bus.reg_waddr = '0; bus.reg_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;

    // Reset and x0
    tick(); tick();
    chk("rst_ack", 32'(bus.dbg_ack), 32'h0);
    chk("rst_busy", 32'(bus.dbg_busy), 32'h0);
    chk("rst_rdata", bus.dbg_rdata, 32'h0);
    rst_n = 1'b1;
    #1;
    for (int i = 1; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      #1;
      chk($sformatf("rst_x%0d", i), bus.rs1_data, 32'h0);
    end
    core_wr(5'd0, 32'hDEADBEEF);
    bus.rs1_addr = 5'd0;
    #1;
    chk("x0_after_wr", bus.rs1_data, 32'h0);

    // Vector table: reads see state before the row's write; no same-cycle collisions
    vecs[0] = '{1'b1, 5'd5,  32'h12345678, 5'd1,  5'd2,  32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd5,  5'd6,  32'h12345678, 32'h0};
    vecs[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 5'd5,  32'h0BADF00D, 5'd31, 5'd0,  32'hFFFFFFFF, 32'h0};
    vecs[4] = '{1'b1, 5'd1,  32'h00000001, 5'd5,  5'd31, 32'h12345678, 32'hFFFFFFFF};
    vecs[5] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd1,  5'd0,  32'h00000001, 32'h0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd1,  32'hCAFEF00D, 32'h00000001};
    for (int i = 0; i < 7; i++) begin
      bus.reg_wen = vecs[i].wen; bus.reg_waddr = vecs[i].waddr; bus.reg_wdata = vecs[i].wdata;
      bus.rs1_addr = vecs[i].a1; bus.rs2_addr = vecs[i].a2;
      #1;
      chk($sformatf("vec%0d_rs1", i), bus.rs1_data, vecs[i].e1);
      chk($sformatf("vec%0d_rs2", i), bus.rs2_data, vecs[i].e2);
      tick();
      if (vecs[i].wen && vecs[i].waddr != 5'd0) mem_m[vecs[i].waddr] = vecs[i].wdata;
    end
    bus.reg_wen = 1'b0;

    // Same-cycle write/read of x7
    core_wr(5'd7, 32'h00000777);
    bus.reg_wen = 1'b1; bus.reg_waddr = 5'd7; bus.reg_wdata = 32'hA5A5A5A5; bus.rs2_addr = 5'd7;
    #1;
`ifdef REGS_BYPASS_EN
    chk("bypass_same", bus.rs2_data, 32'hA5A5A5A5);
`else
    chk("bypass_same", bus.rs2_data, 32'h00000777);
`endif
    tick();
    bus.reg_wen = 1'b0;
    mem_m[7] = 32'hA5A5A5A5;
    #1;
    chk("bypass_next", bus.rs2_data, 32'hA5A5A5A5);

    // Debug read with an ignored second request while busy
    core_wr(5'd3, 32'h00000042);
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 5'd3;
    tick();
    chk("dbgrd_busy", 32'(bus.dbg_busy), 32'h1);
    chk("dbgrd_noack", 32'(bus.dbg_ack), 32'h0);
    bus.dbg_addr = 5'd5;
    tick();
    chk("dbgrd_ack", 32'(bus.dbg_ack), 32'h1);
    chk("dbgrd_rdata", bus.dbg_rdata, 32'h00000042);
    bus.dbg_req = 1'b0;
    tick();
    chk("dbgrd_ack_pulse", 32'(bus.dbg_ack), 32'h0);
    chk("dbgrd_idle", 32'(bus.dbg_busy), 32'h0);
    chk("dbgrd_hold", bus.dbg_rdata, 32'h00000042);
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.dbg_ack === 1'b1 || bus.dbg_busy === 1'b1) lat++;
    end
    chk("dbgrd_ignored_req", 32'(lat), 32'h0);

    // Debug write deferred by 3 core writes to another address
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd9; bus.dbg_wdata = 32'h11;
    tick();
    bus.dbg_req = 1'b0;
    bus.reg_wen = 1'b1; bus.reg_waddr = 5'd4; bus.reg_wdata = 32'h44440000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("cont_noack%0d", i), 32'(bus.dbg_ack), 32'h0);
    end
    bus.reg_wen = 1'b0;
    mem_m[4] = 32'h44440000;
    wait_ack(20, lat);
    chk("cont_lat", 32'(lat), 32'd1);
    bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd4;
    #1;
    chk("cont_x9", bus.rs1_data, 32'h11);
    chk("cont_x4", bus.rs2_data, 32'h44440000);
    mem_m[9] = 32'h11;
    tick();

    // Forced debug write after the wait limit, same address as the core write
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd9; bus.dbg_wdata = 32'h11;
    tick();
    bus.dbg_req = 1'b0;
    bus.reg_wen = 1'b1; bus.reg_waddr = 5'd9; bus.reg_wdata = 32'h22;
    wait_ack(40, lat);
    bus.reg_wen = 1'b0;
    chk("force_lat", 32'(lat), 32'd16);
    bus.rs1_addr = 5'd9;
    #1;
    chk("force_x9", bus.rs1_data, 32'h11);
    tick();

    // Debug write to x0 still acks and stores nothing
    dbg_txn(1'b1, 5'd0, 32'hFFFFFFFF, lat, rd);
    chk("dbg_x0_lat", 32'(lat), 32'd2);
    bus.rs1_addr = 5'd0;
    #1;
    chk("dbg_x0_rd", bus.rs1_data, 32'h0);

    // Random core traffic against the array model
    for (int i = 0; i < 150; i++) begin
      wen = 1'($urandom_range(0, 1)); wa = 5'($urandom_range(0, 31)); wd = $urandom;
      a1 = 5'($urandom_range(0, 31)); a2 = 5'($urandom_range(0, 31));
      bus.reg_wen = wen; bus.reg_waddr = wa; bus.reg_wdata = wd;
      bus.rs1_addr = a1; bus.rs2_addr = a2;
      #1;
      chk("rnd_rs1", bus.rs1_data, model_rd(a1, wen, wa, wd));
      chk("rnd_rs2", bus.rs2_data, model_rd(a2, wen, wa, wd));
      tick();
      if (wen && wa != 5'd0) mem_m[wa] = wd;
    end
    bus.reg_wen = 1'b0;

    // Random debug transactions without contention
    for (int i = 0; i < 10; i++) begin
      wen = 1'($urandom_range(0, 1)); wa = 5'($urandom_range(0, 31)); wd = $urandom;
      dbg_txn(wen, wa, wd, lat, rd);
      chk("rnd_dbg_lat", 32'(lat), 32'd2);
      if (!wen) chk("rnd_dbg_rdata", rd, (wa == 5'd0) ? 32'h0 : mem_m[wa]);
      else if (wa != 5'd0) mem_m[wa] = wd;
      bus.rs1_addr = wa;
      #1;
      chk("rnd_dbg_port", bus.rs1_data, (wa == 5'd0) ? 32'h0 : mem_m[wa]);
    end

    // Reset while a debug write to x10 is stalled in ACCESS
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd10; bus.dbg_wdata = 32'hAAAA5555;
    bus.reg_wen = 1'b1; bus.reg_waddr = 5'd2; bus.reg_wdata = 32'h2;
    tick();
    bus.dbg_req = 1'b0;
    chk("mid_busy", 32'(bus.dbg_busy), 32'h1);
    bus.rs1_addr = 5'd9;
    rst_n = 1'b0;
    #1;
    chk("mid_rd_forced0", bus.rs1_data, 32'h0);
    tick();
    bus.reg_wen = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dbg_ack === 1'b1 || bus.dbg_busy === 1'b1) lat++;
      tick();
    end
    chk("mid_no_ack_idle", 32'(lat), 32'h0);
    bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd9;
    #1;
    chk("mid_x10", bus.rs1_data, 32'h0);
    chk("mid_x9", bus.rs2_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
